// File: rtl/osd_spi_ctrl_if.sv
// OSD link bundle: the three MiST SPI pins going in, the OSD buffer write
// port and status going out.
interface osd_spi_ctrl_if #(
  parameter int BUF_AW = 11
);
  logic              SPI_SCK;
  logic              SPI_SS3;
  logic              SPI_DI;
  logic              osd_enable;
  logic [BUF_AW-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              buf_we;
  logic              busy;

  modport master (
    output SPI_SCK, SPI_SS3, SPI_DI,
    input  osd_enable, buf_addr, buf_data, buf_we, busy
  );

  modport slave (
    input  SPI_SCK, SPI_SS3, SPI_DI,
    output osd_enable, buf_addr, buf_data, buf_we, busy
  );
endinterface

// File: rtl/osd_spi_ctrl.sv
// OSD SPI command decoder: oversamples the SPI pins in clk_sys, assembles
// bytes, toggles overlay visibility or streams bytes into the OSD buffer.
//
// state | meaning
// WAIT  | after reset; ignore the link until SS3 is seen high
// IDLE  | no transfer; bit counter cleared
// CMD   | collecting the command byte
// DATA  | each byte becomes one buffer write, address auto-increments
// SKIP  | consume bytes with no effect until SS3 rises
module osd_spi_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int BUF_AW      = 11
) (
  input  logic           clk_sys,
  input  logic           reset,
  osd_spi_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_SKIP
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss3_sync;
  logic [SYNC_STAGES-1:0] di_sync;
  logic [SYNC_STAGES-1:0] primed;
  logic                   sck_d;

  logic sck_s;
  logic ss3_s;
  logic di_s;
  logic sck_rise;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [6:0]        shift_reg;
  logic [7:0]        byte_next;
  logic              byte_done;
  logic              osd_enable;
  logic [BUF_AW-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              buf_we;

  // SS3 synchronizer resets high so busy reads 0 during and right after reset.
  // primed marks when the synchronizers hold real pin samples again.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sck_sync <= '0;
      ss3_sync <= '1;
      di_sync  <= '0;
      primed   <= '0;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.SPI_SCK};
      ss3_sync <= {ss3_sync[SYNC_STAGES-2:0], bus.SPI_SS3};
      di_sync  <= {di_sync[SYNC_STAGES-2:0], bus.SPI_DI};
      primed   <= {primed[SYNC_STAGES-2:0], 1'b1};
      sck_d    <= sck_s;
    end
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign ss3_s     = ss3_sync[SYNC_STAGES-1];
  assign di_s      = di_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_d;
  assign byte_next = {shift_reg, di_s};
  // ss3_s high masks the edge, so SS3 rising together with SCK wins
  assign byte_done = sck_rise & ~ss3_s & (bit_cnt == 3'd7);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_WAIT;
      bit_cnt    <= 3'd0;
      shift_reg  <= 7'd0;
      osd_enable <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= 8'd0;
      buf_we     <= 1'b0;
    end else begin
      buf_we <= 1'b0;
      if (buf_we)
        buf_addr <= buf_addr + 1'b1;

      if (state == ST_WAIT) begin
        bit_cnt <= 3'd0;
        if (primed[SYNC_STAGES-1] && ss3_s)
          state <= ST_IDLE;
      end else if (ss3_s) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
      end else begin
        if (state == ST_IDLE)
          state <= ST_CMD;
        if (sck_rise) begin
          shift_reg <= byte_next[6:0];
          bit_cnt   <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            ST_CMD: begin
              if (byte_next[7:4] == 4'h4) begin
                osd_enable <= byte_next[0];
                state      <= ST_SKIP;
              end else if (byte_next[7:3] == 5'b00100) begin
                buf_addr <= BUF_AW'({byte_next[2:0], 8'h00});
                state    <= ST_DATA;
              end else begin
                state <= ST_SKIP;
              end
            end
            ST_DATA: begin
              buf_we   <= 1'b1;
              buf_data <= byte_next;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.osd_enable = osd_enable;
  assign bus.buf_addr   = buf_addr;
  assign bus.buf_data   = buf_data;
  assign bus.buf_we     = buf_we;
  assign bus.busy       = ~ss3_s;

endmodule

// File: tb/tb_osd_spi_ctrl.sv
// Bench for osd_spi_ctrl: drives SPI transfers at the minimum SCK period and
// compares buffer writes and overlay state against a transfer-level model.
`timescale 1ns/1ps
module tb_osd_spi_ctrl;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  osd_spi_ctrl_if #(.BUF_AW(11)) bus ();

  osd_spi_ctrl #(.SYNC_STAGES(2), .BUF_AW(11)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  logic [18:0] obs_q[$];
  logic [18:0] exp_q[$];
  logic        model_en = 1'b0;
  int          dbl_we   = 0;
  logic        we_prev  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // capture every write strobe and catch back-to-back strobes
  always @(negedge clk_sys) begin
    if (bus.buf_we)
      obs_q.push_back({bus.buf_addr, bus.buf_data});
    if (bus.buf_we && we_prev)
      dbl_we++;
    we_prev = bus.buf_we;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic spi_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.SPI_DI  = v[7-i];
      bus.SPI_SCK = 1'b0;
      tick(2);
      bus.SPI_SCK = 1'b1;
      tick(2);
    end
    bus.SPI_SCK = 1'b0;
  endtask

  task automatic ss_low();
    bus.SPI_SS3 = 1'b0;
    tick(4);
    check("busy_active", bus.busy, 1);
  endtask

  task automatic ss_high();
    bus.SPI_SCK = 1'b0;
    tick(2);
    bus.SPI_SS3 = 1'b1;
    tick(8);
  endtask

  // reference: first byte is the command, the remaining whole bytes are payload
  task automatic model_xfer(input logic [7:0] b[$]);
    logic [10:0] addr;
    logic        wr;
    wr   = 1'b0;
    addr = '0;
    if (b.size() == 0) return;
    if (b[0][7:4] == 4'h4) begin
      model_en = b[0][0];
    end else if (b[0][7:3] == 5'b00100) begin
      wr   = 1'b1;
      addr = {b[0][2:0], 8'h00};
    end
    if (wr) begin
      for (int i = 1; i < b.size(); i++) begin
        exp_q.push_back({addr, b[i]});
        addr = addr + 11'd1;
      end
    end
  endtask

  task automatic check_writes(input string tag);
    logic [18:0] o;
    logic [18:0] e;
    tick(4);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_wr"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_osd_en"}, bus.osd_enable, model_en);
    check({tag, "_busy_idle"}, bus.busy, 0);
  endtask

  task automatic send_xfer(input string tag, input logic [7:0] b[$]);
    ss_low();
    foreach (b[i]) spi_bits(b[i], 8);
    ss_high();
    model_xfer(b);
    check_writes(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] r;
    bus.SPI_SCK = 1'b0;
    bus.SPI_SS3 = 1'b1;
    bus.SPI_DI  = 1'b0;
    tick(4);
    check("rst_osd_en", bus.osd_enable, 0);
    check("rst_we", bus.buf_we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_addr", bus.buf_addr, 0);
    check("rst_data", bus.buf_data, 0);
    reset = 1'b0;
    tick(6);

    // enable / disable
    q = '{8'h41};
    send_xfer("en_on", q);
    q = '{8'h40};
    send_xfer("en_off", q);

    // line write
    q = '{8'h23, 8'hAA, 8'h55, 8'h0F};
    send_xfer("line", q);

    // wrap-around from 0x7FF to 0x000
    q = '{8'h27};
    for (int i = 0; i < 257; i++) q.push_back(8'($urandom));
    send_xfer("wrap", q);

    // abort after 5 bits of the first data byte
    q = '{8'h41};
    send_xfer("en_on2", q);
    ss_low();
    spi_bits(8'h21, 8);
    spi_bits(8'hC3, 5);
    ss_high();
    q = '{8'h21};
    model_xfer(q);
    check_writes("abort");
    q = '{8'h99, 8'h12};
    send_xfer("unknown", q);

    // reset in the middle of a write transfer, SS3 held low
    ss_low();
    q = '{8'h20, 8'($urandom), 8'($urandom)};
    foreach (q[i]) spi_bits(q[i], 8);
    tick(6);
    model_xfer(q);
    reset = 1'b1;
    tick(2);
    check("midrst_osd_en", bus.osd_enable, 0);
    check("midrst_we", bus.buf_we, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_addr", bus.buf_addr, 0);
    reset    = 1'b0;
    model_en = 1'b0;
    for (int i = 0; i < 3; i++) spi_bits(8'($urandom), 8);
    ss_high();
    check_writes("midrst");
    q = '{8'h20, 8'h77};
    send_xfer("post_rst", q);

    // random write transfers at the minimum SCK period
    for (int k = 0; k < 3; k++) begin
      r = 8'h20 | 8'($urandom_range(0, 7));
      q = '{r};
      for (int i = 0; i < 40; i++) q.push_back(8'($urandom));
      send_xfer("rand", q);
    end

    check("we_back_to_back", dbl_we, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
